moore_frame_scheduler: RTL and testbench
========================================

// Module: moore_frame_scheduler
// PURPOSE
//  Shares one 2-bit T-flip-flop Moore core between NUM_REQ serial requesters.
//  Core equations: TA = x & B, TB = x, y = A & B.
//  A round-robin arbiter grants the core, clears its state and streams FRAME_LEN
//  bits from the granted requester into it. It counts Moore hits (y=1) and
//  returns the count with a done pulse. Sits between bit-serial sources and the core.
// PARAMETERS
//  NUM_REQ    2   number of requesters (2..8)
//  FRAME_LEN  8   bits per frame (>=1)
//  CNT_W      $clog2(FRAME_LEN+1)  hit-counter width (derived, do not override)
// PORTS
//  clk     in   1        rising-edge clock
//  res     in   1        asynchronous active-low reset
//  req     in   NUM_REQ  request; hold high until matching done
//  x_in    in   NUM_REQ  serial data bit per requester
//  gnt     out  NUM_REQ  one-hot grant, high LOAD..DONE
//  done    out  NUM_REQ  1-cycle pulse to granted requester in DONE
//  hits    out  CNT_W    hit count of last completed frame, held until next DONE
//  busy    out  1        high in any state except IDLE
//  abort   out  1        1-cycle abort pulse (tied 0 unless macro enabled)
//  A, B    out  1 each   core state bits, for monitoring
//  y_mon   out  1        core output A & B
// BEHAVIOUR
//  Reset (res=0, async): state IDLE, gnt=0, done=0, hits=0, busy=0, abort=0, A=B=0,
//   rr pointer = NUM_REQ-1, so req[0] wins first.
//  FSM: IDLE -> LOAD -> RUN (FRAME_LEN cycles) -> DRAIN -> DONE -> IDLE.
//  IDLE: if any req, pick first set index after rr pointer (wrapping). Register gnt. Go to LOAD.
//  LOAD: core synchronously cleared (A=B=0); bit counter=0; hit accumulator=0.
//  RUN: each edge core samples x_in[granted]. Accumulator += y_mon (pre-update state).
//   Bit counter += 1. Leave after FRAME_LEN edges.
//  DRAIN: accumulator += y_mon (state after last bit); core holds (T=0).
//  DONE: hits <= accumulator; done[granted]=1; rr pointer <= granted; then IDLE (gnt drops).
//  Latency: req seen in IDLE cycle t -> LOAD at t+1 -> done pulse at t+FRAME_LEN+3.
//  Back-to-back: a requester still high in IDLE after DONE loses to any other pending
//   requester (fair rotation). A lone requester is regranted immediately.
//  req changes of non-granted requesters during a frame: ignored until IDLE.
//  Core runs only in RUN: T inputs forced 0 in IDLE/DRAIN/DONE; clear only in LOAD.
//  Reset mid-frame: immediate return to reset values; no done pulse.
//  Accumulator cannot overflow: max FRAME_LEN hits fit in CNT_W.
// CONFIGURATION
//  MOORE_SCHED_ABORT_EN defined: req[granted] low in any RUN cycle aborts. Next state is IDLE.
//   abort=1 for one cycle. No done pulse; hits unchanged; rr pointer <= granted.
//  Undefined: a req drop during a frame is ignored; the frame completes normally; abort=0.
// STRUCTURE
//  Package moore_sched_pkg: state enum typedef (IDLE, LOAD, RUN, DRAIN, DONE) and the
//   CNT_W / counter-width localparam helper.
//  Sub-module moore_tff_core: two T flip-flops with async active-low reset and sync clear.
//   Inputs x, en, clr; outputs A, B, y.
//  Top level: arbiter, FSM, bit counter, hit accumulator, x mux.
// TESTING (NUM_REQ=2, FRAME_LEN=8)
//  1 Reset released, req=00 -> busy=0, gnt=00, hits=0, A=B=0 held indefinitely.
//  2 req=01, x_in[0]=1 all 8 bits. States 01,10,11,00,01,10,11,00 -> hits=2.
//    done[0] pulses 11 cycles after req seen.
//  3 req=10, x_in[1]=1,1,1,0,0,0,0,0 -> state 11 from bit 3 on -> hits=6, done[1] only.
//  4 req=11 held -> grants alternate 01,10,01...; x all 0 -> hits=0 each frame.
//  5 Assert res low mid-RUN -> all outputs to reset values within same cycle.
//    No done pulse; the next frame starts fresh.
//  6 Drop req[0] at RUN bit 4: macro off -> frame completes, done[0] pulses.
//    Macro on -> abort pulses, FSM goes to IDLE, hits keeps its prior value.

Source files
------------

// File: rtl/moore_sched_pkg.sv
// Shared types for the Moore frame scheduler: FSM state encoding and the
// helper that sizes the hit counter from the frame length.
package moore_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Enough bits to hold a hit count of 0..frame_len.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/moore_tff_core.sv
// Two-T-flip-flop Moore core: TA = x & B, TB = x, y = A & B.
// Async active-low reset, synchronous clear (wins over enable); the state
// only moves while en is high.
module moore_tff_core (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic en,
    input  logic clr,
    output logic A,
    output logic B,
    output logic y
);

    logic a_q, b_q;

    // T flip-flop pair; toggles only when enabled, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
        end else if (clr) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
        end else if (en) begin
            a_q <= a_q ^ (x & b_q);
            b_q <= b_q ^ x;
        end
    end

    assign A = a_q;
    assign B = b_q;
    assign y = a_q & b_q;

endmodule

// File: rtl/moore_frame_scheduler.sv
// Round-robin scheduler sharing one Moore core between NUM_REQ bit-serial
// requesters. Each grant: LOAD clears the core, RUN streams FRAME_LEN bits,
// DRAIN folds in the final core output, DONE publishes the hit count.
// Optional feature: define MOORE_SCHED_ABORT_EN to abort a frame when the
// granted requester drops req during RUN.
module moore_frame_scheduler
    import moore_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] x_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [CNT_W-1:0]   hits,
    output logic               busy,
    output logic               abort,
    output logic               A,
    output logic               B,
    output logic               y_mon
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q;
    logic [IDX_W-1:0]   gidx_q, rr_q;
    logic [NUM_REQ-1:0] gnt_q, done_q;
    logic [CNT_W-1:0]   bitcnt_q, acc_q, hits_q;
    logic               abort_q;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               core_x, core_en, core_clr;

    // Round-robin pick: first requester after rr_q, wrapping. Scanning from
    // the farthest distance down leaves the nearest pending index in pick_idx.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            int idx;
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end

    // The core only advances in RUN and is cleared only in LOAD.
    assign core_x   = x_in[gidx_q];
    assign core_en  = (state_q == RUN);
    assign core_clr = (state_q == LOAD);

    moore_tff_core u_core (
        .clk   (clk),
        .rst_n (res),
        .x     (core_x),
        .en    (core_en),
        .clr   (core_clr),
        .A     (A),
        .B     (B),
        .y     (y_mon)
    );

    // Frame FSM with arbiter pointer, bit counter, accumulator and outputs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            gidx_q   <= '0;
            rr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            bitcnt_q <= '0;
            acc_q    <= '0;
            hits_q   <= '0;
            abort_q  <= 1'b0;
        end else begin
            done_q  <= '0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gidx_q  <= pick_idx;
                        gnt_q   <= NUM_REQ'(1) << pick_idx;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    bitcnt_q <= '0;
                    acc_q    <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
`ifdef MOORE_SCHED_ABORT_EN
                    if (!req[gidx_q]) begin
                        abort_q <= 1'b1;
                        gnt_q   <= '0;
                        rr_q    <= gidx_q;
                        state_q <= IDLE;
                    end else
`endif
                    begin
                        // y_mon here is the state before this edge's update.
                        acc_q    <= acc_q + CNT_W'(y_mon);
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == CNT_W'(FRAME_LEN - 1))
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Fold in the state left by the last bit and publish it,
                    // so hits and done are both visible during DONE.
                    acc_q   <= acc_q + CNT_W'(y_mon);
                    hits_q  <= acc_q + CNT_W'(y_mon);
                    done_q  <= gnt_q;
                    state_q <= DONE;
                end
                DONE: begin
                    rr_q    <= gidx_q;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign hits  = hits_q;
    assign busy  = (state_q != IDLE);
    assign abort = abort_q;

endmodule

// File: tb/tb_moore_frame_scheduler.sv
// Bench for moore_frame_scheduler (NUM_REQ=2, FRAME_LEN=8): table of
// directed frames, randomized frames against a counter-level model, plus
// mid-frame reset and req-drop sequences.
module tb_moore_frame_scheduler;

    logic       clk = 1'b0;
    logic       res;
    logic [1:0] req, x_in, gnt, done;
    logic [3:0] hits;
    logic       busy, abort, A, B, y_mon;

    int nvec = 0;
    int nerr = 0;
    int last_g = 1;
    int last_hits = 0;

    always #5 clk = ~clk;

    moore_frame_scheduler #(.NUM_REQ(2), .FRAME_LEN(8)) dut (
        .clk(clk), .res(res), .req(req), .x_in(x_in), .gnt(gnt), .done(done),
        .hits(hits), .busy(busy), .abort(abort), .A(A), .B(B), .y_mon(y_mon)
    );

    typedef struct {
        logic [1:0] rq;
        logic [7:0] x0;
        logic [7:0] x1;
        logic [1:0] g;
        int         h;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core seen as a 2-bit counter that increments when x=1; a hit is a
    // count of 3 seen before each bit and once more after the last bit.
    function automatic int model_hits(input logic [7:0] xs);
        int s = 0;
        int h = 0;
        for (int i = 0; i < 8; i++) begin
            if (s == 3) h++;
            s = (s + int'(xs[i])) % 4;
        end
        if (s == 3) h++;
        return h;
    endfunction

    function automatic int model_pick(input logic [1:0] rq, input int last);
        for (int k = 1; k <= 2; k++) begin
            int idx;
            idx = (last + k) % 2;
            if (rq[idx]) return idx;
        end
        return -1;
    endfunction

    // Entered at the negedge of an IDLE cycle; leaves at the negedge of the
    // IDLE cycle following the frame.
    task automatic run_frame(input logic [1:0] rq, input logic [7:0] x0, input logic [7:0] x1,
                             input logic [1:0] exp_g, input int exp_h, input int drop_bit);
        logic early;
        early = 1'b0;
        req = rq;
        @(negedge clk);
        check("load_gnt", gnt, exp_g);
        check("load_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done != 2'b00) early = 1'b1;
            x_in = {x1[i], x0[i]};
            if (i == drop_bit) req = req & ~exp_g;
`ifdef MOORE_SCHED_ABORT_EN
            if (i == drop_bit) begin
                @(negedge clk);
                check("abort_pulse", abort, 1);
                check("abort_busy", busy, 0);
                check("abort_gnt", gnt, 0);
                check("abort_hits", hits, last_hits);
                check("abort_done", done, 0);
                return;
            end
`endif
        end
        @(negedge clk);
        if (done != 2'b00) early = 1'b1;
        check("done_early", early, 0);
        @(negedge clk);
        check("done_pulse", done, exp_g);
        check("hits", hits, exp_h);
        check("abort_zero", abort, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);
        check("done_drop", done, 0);
        last_hits = exp_h;
    endtask

    initial begin
        tbl[0] = '{2'b01, 8'hFF, 8'h00, 2'b01, 2};
        tbl[1] = '{2'b10, 8'hFF, 8'h07, 2'b10, 6};
        tbl[2] = '{2'b11, 8'h00, 8'hFF, 2'b01, 0};
        tbl[3] = '{2'b11, 8'hFF, 8'h00, 2'b10, 0};
        tbl[4] = '{2'b11, 8'h55, 8'hFF, 2'b01, 2};
        tbl[5] = '{2'b10, 8'h00, 8'h87, 2'b10, 5};
        tbl[6] = '{2'b10, 8'hFF, 8'hFF, 2'b10, 2};

        res = 1'b0; req = 2'b00; x_in = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_state", {busy, gnt, done, hits, abort, A, B}, 0);
        res = 1'b1;

        // Idle with no requests stays quiet.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_quiet", {busy, gnt, done, hits, abort, A, B}, 0);
        end

        // Directed frames: counting patterns, rotation, lone regrant.
        for (int v = 0; v < 7; v++) begin
            run_frame(tbl[v].rq, tbl[v].x0, tbl[v].x1, tbl[v].g, tbl[v].h, -1);
            last_g = tbl[v].g[1] ? 1 : 0;
        end

        // Randomized frames against the model.
        for (int n = 0; n < 20; n++) begin
            logic [1:0] rq;
            logic [7:0] x0, x1;
            int g;
            rq = 2'($urandom_range(1, 3));
            x0 = 8'($urandom);
            x1 = 8'($urandom);
            g  = model_pick(rq, last_g);
            run_frame(rq, x0, x1, 2'(1 << g), model_hits(g == 1 ? x1 : x0), -1);
            last_g = g;
        end

        // Reset in the middle of RUN.
        req = 2'b01; x_in = 2'b11;
        repeat (5) @(negedge clk);
        res = 1'b0;
        #1;
        check("midrst_outs", {busy, gnt, done, hits, abort, A, B, y_mon}, 0);
        req = 2'b00;
        @(negedge clk);
        check("midrst_nodone", done, 0);
        res = 1'b1;
        last_g = 1; last_hits = 0;
        @(negedge clk);
        run_frame(2'b01, 8'hFF, 8'h00, 2'b01, 2, -1);
        last_g = 0;

        // Granted requester drops req at RUN bit 4.
        run_frame(2'b10, 8'h00, 8'h07, 2'b10, 6, -1);
        last_g = 1;
        run_frame(2'b01, 8'h07, 8'h00, 2'b01, model_hits(8'h07), 4);
        last_g = 0;
        req = 2'b00;
        @(negedge clk);
        check("post_drop_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
